// File: rtl/cam_pixel_plotter_if.sv
// SRAM controller read/write/ready handshake shared by the pixel plotter (master)
// and the SRAM controller (slave).
interface cam_pixel_plotter_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] address;
    logic [15:0]       data_write;
    logic [15:0]       data_read;
    logic              read;
    logic              write;
    logic              ready;

    modport master (
        output address, data_write, read, write,
        input  data_read, ready
    );

    modport slave (
        input  address, data_write, read, write,
        output data_read, ready
    );
endinterface

// File: rtl/cam_pixel_plotter.sv
// Plots scaled camera blob points into the 1-bpp SRAM framebuffer by read-modify-write,
// and sweeps the framebuffer to zero on request. Define BRUSH_2X2_EN for a 2x2 brush.
module cam_pixel_plotter #(
    parameter int H_WORDS  = 40,
    parameter int FB_WORDS = 19200,
    parameter int ADDR_W   = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       plot,
    input  logic                       clear,
    input  logic [9:0]                 x,
    input  logic [9:0]                 y,
    cam_pixel_plotter_if.master        sram,
    output logic                       busy,
    output logic                       done
);

    localparam logic [9:0]        PX_MAX    = 10'(H_WORDS * 16 - 1);
    localparam logic [9:0]        PY_MAX    = 10'(FB_WORDS / H_WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    typedef enum logic [3:0] {
        IDLE, SCALE, RD, RD_WAIT, WR, WR_WAIT, NEXT, CLR, CLR_WAIT
    } state_t;

    state_t      r_state;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [15:0] r_mask;
    logic [15:0] r_data;

    logic [9:0]        w_px;
    logic [9:0]        w_py;
    logic [9:0]        w_pxB;
    logic [9:0]        w_pyB;
    logic              w_dx;
    logic              w_dy;
    logic              w_clip;
    logic              w_skip;
    logic [15:0]       w_mask;
    logic [ADDR_W-1:0] w_addr;

`ifdef BRUSH_2X2_EN
    // Brush pixel index: bit 0 is the x offset, bit 1 the y offset.
    logic [1:0] r_pix;
    assign w_dx = r_pix[0];
    assign w_dy = r_pix[1];
`else
    assign w_dx = 1'b0;
    assign w_dy = 1'b0;
`endif

    // Scale by 5/8 (1024->640, 768->480) with shift-add, then word address = px/16 + py*40.
    assign w_px   = 10'(({3'b000, r_x} + {1'b0, r_x, 2'b00}) >> 3);
    assign w_py   = 10'(({3'b000, r_y} + {1'b0, r_y, 2'b00}) >> 3);
    assign w_pxB  = w_px + {9'b0, w_dx};
    assign w_pyB  = w_py + {9'b0, w_dy};
    assign w_addr = ADDR_W'(w_pxB[9:4]) + (ADDR_W'(w_pyB) << 5) + (ADDR_W'(w_pyB) << 3);
    assign w_mask = 16'h8000 >> w_pxB[3:0];
    assign w_clip = (w_pxB > PX_MAX) || (w_pyB > PY_MAX);
    assign w_skip = (y >= 10'd768) || ((x == 10'd1023) && (y == 10'd1023));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_x             <= '0;
            r_y             <= '0;
            r_mask          <= '0;
            r_data          <= '0;
            sram.address    <= '0;
            sram.data_write <= '0;
            sram.read       <= 1'b0;
            sram.write      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
`ifdef BRUSH_2X2_EN
            r_pix           <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clear) begin
                        busy         <= 1'b1;
                        sram.address <= '0;
                        r_state      <= CLR;
                    end else if (plot && !w_skip) begin
                        r_x     <= x;
                        r_y     <= y;
                        busy    <= 1'b1;
                        r_state <= SCALE;
`ifdef BRUSH_2X2_EN
                        r_pix   <= '0;
`endif
                    end
                end
                SCALE: begin
                    if (w_clip) begin
                        r_state <= NEXT;
                    end else begin
                        sram.address <= w_addr;
                        r_mask       <= w_mask;
                        r_state      <= RD;
                    end
                end
                RD: begin
                    sram.read <= 1'b1;
                    r_state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (sram.ready) begin
                        r_data    <= sram.data_read;
                        sram.read <= 1'b0;
                        r_state   <= WR;
                    end
                end
                WR: begin
                    sram.data_write <= r_data | r_mask;
                    sram.write      <= 1'b1;
                    r_state         <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (sram.ready) begin
                        sram.write <= 1'b0;
                        r_state    <= NEXT;
                    end
                end
                NEXT: begin
`ifdef BRUSH_2X2_EN
                    if (r_pix != 2'd3) begin
                        r_pix   <= r_pix + 2'd1;
                        r_state <= SCALE;
                    end else
`endif
                    begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                CLR: begin
                    sram.data_write <= '0;
                    sram.write      <= 1'b1;
                    r_state         <= CLR_WAIT;
                end
                CLR_WAIT: begin
                    if (sram.ready) begin
                        sram.write <= 1'b0;
                        if (sram.address == LAST_ADDR) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            sram.address <= sram.address + 1'b1;
                            r_state      <= CLR;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_pixel_plotter.sv
// Self-checking bench for cam_pixel_plotter: SRAM responder with random ready latency
// and a coordinate-level reference model of the plotted framebuffer.
module tb_cam_pixel_plotter;

    localparam int FB_WORDS = 19200;

    logic       clk = 1'b0;
    logic       reset;
    logic       plot;
    logic       clear;
    logic [9:0] x;
    logic [9:0] y;
    logic       busy;
    logic       done;

    cam_pixel_plotter_if #(.ADDR_W(18)) bus ();

    cam_pixel_plotter dut (
        .clk   (clk),
        .reset (reset),
        .plot  (plot),
        .clear (clear),
        .x     (x),
        .y     (y),
        .sram  (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] mem    [FB_WORDS];
    logic [15:0] refMem [FB_WORDS];
    int          rdAddrQ[$];
    int          wrAddrQ[$];
    logic [15:0] wrDataQ[$];
    int          expAddrQ[$];
    logic [15:0] expDataQ[$];
    int          readyDelay = 1;
    int          hsErr = 0;
    int          doneCnt = 0;
    bit          busySeen = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // SRAM controller model plus done/busy monitor, all sampled on the falling edge.
    initial begin
        int cnt;
        int addr;
        logic [17:0] strobeAddr;
        logic [15:0] strobeData;
        cnt = 0;
        strobeAddr = '0;
        strobeData = '0;
        bus.ready = 1'b0;
        bus.data_read = '0;
        forever begin
            @(negedge clk);
            if (done) doneCnt++;
            if (busy) busySeen = 1'b1;
            if (reset) begin
                bus.ready = 1'b0;
                cnt = 0;
            end else if (bus.ready) begin
                if (bus.read || bus.write) hsErr++;
                bus.ready = 1'b0;
                cnt = 0;
            end else if (bus.read || bus.write) begin
                if (bus.read && bus.write) hsErr++;
                if (cnt == 0) begin
                    strobeAddr = bus.address;
                    strobeData = bus.data_write;
                end else if (bus.address !== strobeAddr || (bus.write && bus.data_write !== strobeData)) begin
                    hsErr++;
                end
                cnt++;
                if (cnt >= readyDelay) begin
                    addr = int'(bus.address);
                    if (addr >= FB_WORDS) begin
                        hsErr++;
                        addr = 0;
                    end
                    if (bus.read) begin
                        rdAddrQ.push_back(addr);
                        bus.data_read = mem[addr];
                    end else begin
                        wrAddrQ.push_back(addr);
                        wrDataQ.push_back(bus.data_write);
                        mem[addr] = bus.data_write;
                    end
                    bus.ready = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Reference: 640x480 pixel = camera*5/8; brush pixels in raster order, clipped at the screen edge.
    task automatic modelPlot(input int cx, input int cy);
        int px, py, qx, qy, a, brushN;
        expAddrQ.delete();
        expDataQ.delete();
`ifdef BRUSH_2X2_EN
        brushN = 4;
`else
        brushN = 1;
`endif
        if (cy >= 768) return;
        px = (cx * 5) / 8;
        py = (cy * 5) / 8;
        for (int p = 0; p < brushN; p++) begin
            qx = px + (p % 2);
            qy = py + (p / 2);
            if (qx < 640 && qy < 480) begin
                a = qy * 40 + qx / 16;
                refMem[a] = refMem[a] | (16'h1 << (15 - (qx % 16)));
                expAddrQ.push_back(a);
                expDataQ.push_back(refMem[a]);
            end
        end
    endtask

    task automatic applyStimulus(input int cx, input int cy, input bit withClear);
        @(negedge clk);
        x = 10'(cx);
        y = 10'(cy);
        plot = 1'b1;
        clear = withClear;
        @(negedge clk);
        plot = 1'b0;
        clear = 1'b0;
    endtask

    task automatic clearLogs();
        rdAddrQ.delete();
        wrAddrQ.delete();
        wrDataQ.delete();
    endtask

    task automatic waitDone(input int start, input int maxCycles);
        int n = 0;
        while (doneCnt == start && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic runPlot(input string tag, input int cx, input int cy, input bit doubleStrobe);
        int start;
        clearLogs();
        busySeen = 1'b0;
        start = doneCnt;
        modelPlot(cx, cy);
        applyStimulus(cx, cy, 1'b0);
        if (doubleStrobe) applyStimulus(500, 500, 1'b0);
        if (expAddrQ.size() == 0) begin
            repeat (20) @(negedge clk);
            checkOutput({tag, ".busySeen"}, 32'(busySeen), 32'd0);
        end else begin
            waitDone(start, 2000);
        end
        checkOutput({tag, ".doneCount"}, 32'(doneCnt - start), (expAddrQ.size() == 0) ? 32'd0 : 32'd1);
        checkOutput({tag, ".writes"}, 32'(wrAddrQ.size()), 32'(expAddrQ.size()));
        checkOutput({tag, ".reads"}, 32'(rdAddrQ.size()), 32'(expAddrQ.size()));
        for (int i = 0; i < expAddrQ.size(); i++) begin
            if (i < wrAddrQ.size()) begin
                checkOutput({tag, ".wrAddr"}, 32'(wrAddrQ[i]), 32'(expAddrQ[i]));
                checkOutput({tag, ".wrData"}, 32'(wrDataQ[i]), 32'(expDataQ[i]));
            end
            if (i < rdAddrQ.size()) checkOutput({tag, ".rdAddr"}, 32'(rdAddrQ[i]), 32'(expAddrQ[i]));
        end
        checkOutput({tag, ".busyAfter"}, 32'(busy), 32'd0);
        checkOutput({tag, ".handshake"}, 32'(hsErr), 32'd0);
    endtask

    initial begin
        int start, n, bad, cx, cy;
        reset = 1'b1;
        plot = 1'b0;
        clear = 1'b0;
        x = '0;
        y = '0;
        for (int i = 0; i < FB_WORDS; i++) begin
            mem[i] = 16'($urandom);
            refMem[i] = mem[i];
        end
        mem[0] = 16'h0000;      refMem[0] = 16'h0000;
        mem[19199] = 16'h1230;  refMem[19199] = 16'h1230;
        mem[5003] = 16'h8000;   refMem[5003] = 16'h8000;

        #1;
        checkOutput("rst.read",    32'(bus.read),       32'd0);
        checkOutput("rst.write",   32'(bus.write),      32'd0);
        checkOutput("rst.busy",    32'(busy),           32'd0);
        checkOutput("rst.done",    32'(done),           32'd0);
        checkOutput("rst.address", 32'(bus.address),    32'd0);
        checkOutput("rst.wdata",   32'(bus.data_write), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] reset asserted while waiting for read ready");
        readyDelay = 1000000;
        clearLogs();
        applyStimulus(0, 0, 1'b0);
        n = 0;
        while (!bus.read && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midRst.readSeen", 32'(bus.read), 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("midRst.read",  32'(bus.read),  32'd0);
        checkOutput("midRst.write", 32'(bus.write), 32'd0);
        checkOutput("midRst.busy",  32'(busy),      32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        readyDelay = 2;
        repeat (20) @(negedge clk);
        checkOutput("midRst.noWrite", 32'(wrAddrQ.size()), 32'd0);

        $display("[TB] directed plots");
        readyDelay = 1;
        runPlot("origin", 0, 0, 1'b0);
        checkOutput("origin.addr0", (wrAddrQ.size() > 0) ? 32'(wrAddrQ[0]) : 32'hFFFF_FFFF, 32'd0);
        checkOutput("origin.data0", (wrDataQ.size() > 0) ? 32'(wrDataQ[0]) : 32'hFFFF_FFFF, 32'h8000);

        readyDelay = 2;
        runPlot("corner", 1023, 767, 1'b0);
        checkOutput("corner.addr0", (wrAddrQ.size() > 0) ? 32'(wrAddrQ[0]) : 32'hFFFF_FFFF, 32'd19199);
        checkOutput("corner.data0", (wrDataQ.size() > 0) ? 32'(wrDataQ[0]) : 32'hFFFF_FFFF, 32'h1231);

        readyDelay = 3;
        runPlot("mid", 100, 200, 1'b1);
        checkOutput("mid.addr0", (wrAddrQ.size() > 0) ? 32'(wrAddrQ[0]) : 32'hFFFF_FFFF, 32'd5003);
        checkOutput("mid.data0", (wrDataQ.size() > 0) ? 32'(wrDataQ[0]) : 32'hFFFF_FFFF, 32'h8002);

        runPlot("noBlob", 1023, 1023, 1'b0);
        runPlot("yRange", 10, 768, 1'b0);

        $display("[TB] randomized plots");
        for (int t = 0; t < 30; t++) begin
            readyDelay = $urandom_range(1, 4);
            cx = $urandom_range(0, 1023);
            cy = ($urandom_range(0, 7) == 0) ? $urandom_range(768, 1023) : $urandom_range(0, 767);
            runPlot("rand", cx, cy, 1'b0);
        end

        $display("[TB] clear sweep with simultaneous plot");
        readyDelay = 1;
        clearLogs();
        start = doneCnt;
        applyStimulus(100, 200, 1'b1);
        waitDone(start, 60000);
        repeat (10) @(negedge clk);
        checkOutput("clr.doneCount", 32'(doneCnt - start), 32'd1);
        checkOutput("clr.writes",    32'(wrAddrQ.size()), 32'(FB_WORDS));
        checkOutput("clr.reads",     32'(rdAddrQ.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < wrAddrQ.size(); i++) begin
            if (wrAddrQ[i] != i || wrDataQ[i] !== 16'h0000) bad++;
        end
        checkOutput("clr.orderData", 32'(bad), 32'd0);
        checkOutput("clr.busyAfter", 32'(busy), 32'd0);
        checkOutput("clr.handshake", 32'(hsErr), 32'd0);
        for (int i = 0; i < FB_WORDS; i++) refMem[i] = 16'h0000;

        readyDelay = 2;
        runPlot("postClr", 1023, 767, 1'b0);
        runPlot("postClr2", 513, 300, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
